// File: rtl/dma_addr_word_gen.sv
// DMA address/word-count generator: programmable control, initial-address and
// word-count registers driving an address counter and a word counter with a completion flag.
module dma_addr_word_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] di,
    input  logic [1:0]       sel,
    input  logic             plwr,
    input  logic             reinit,
    input  logic             aci,
    input  logic             wci,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] addr,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_WC_DEC  = 2'b00,
        MODE_WC_CMP  = 2'b01,
        MODE_AC_CMP  = 2'b10,
        MODE_FREE    = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [2:0]       cr;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] wr;
    logic [WIDTH-1:0] wc;
    logic [WIDTH-1:0] ac_next;
    logic [WIDTH-1:0] wc_next;
    mode_t            mode;
    logic             wr_cr;
    logic             wr_ar;
    logic             wr_wr;

    assign mode  = mode_t'(cr[1:0]);
    assign wr_cr = !plwr && (sel == 2'd0);
    assign wr_ar = !plwr && (sel == 2'd1);
    assign wr_wr = !plwr && (sel == 2'd2);

    // Lowest to highest priority: count, reload, then a direct register write.
    always_comb begin
        ac_next = ac;
        if (aci)
            ac_next = cr[2] ? ac - ONE : ac + ONE;
        if (reinit)
            ac_next = ar;
        if (wr_ar)
            ac_next = di;
    end

    always_comb begin
        wc_next = wc;
        if (wci)
            wc_next = (mode == MODE_WC_DEC) ? wc - ONE : wc + ONE;
        if (reinit)
            wc_next = (mode == MODE_WC_DEC) ? wr : '0;
        if (wr_wr)
            wc_next = (mode == MODE_WC_DEC) ? di : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr <= '0;
            ar <= '0;
            ac <= '0;
            wr <= '0;
            wc <= '0;
        end else begin
            if (wr_cr)
                cr <= di[2:0];
            if (wr_ar)
                ar <= di;
            if (wr_wr)
                wr <= di;
            ac <= ac_next;
            wc <= wc_next;
        end
    end

    always_comb begin
        dout = '0;
        unique case (sel)
            2'd0: dout = WIDTH'(cr);
            2'd1: dout = ac;
            2'd2: dout = wr;
            2'd3: dout = wc;
        endcase
    end

    always_comb begin
        done = 1'b0;
        unique case (mode)
            MODE_WC_DEC: done = (wc == '0);
            MODE_WC_CMP: done = (wc == wr);
            MODE_AC_CMP: done = (ac == wr);
            MODE_FREE:   done = 1'b0;
        endcase
    end

    assign addr = ac;

endmodule
